// File: rtl/mgt_01_fp_mul_normround_pkg.sv
// Shared types and constants for the FP multiply normalise/round stage.
package mgt_01_fp_mul_normround_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned EXP_W   = 10;
  localparam int unsigned MANT_W  = 23;
  localparam int unsigned PROD_W  = 48;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  localparam logic [XLEN-1:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORMALIZE,
    ST_ROUND,
    ST_VALID
  } state_e;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  // Assemble a binary32 word from its fields.
  function automatic logic [XLEN-1:0] pack_fp(input logic s, input logic [7:0] e,
                                              input logic [MANT_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/mgt_01_fp_mul_normround_if.sv
// Operand/result bundle between FP unpack, this stage and the FP writeback.
interface mgt_01_fp_mul_normround_if;
  import mgt_01_fp_mul_normround_pkg::*;

  logic [2*XLEN-1:0] product_i;
  logic              product_valid_i;
  logic              sign_i;
  logic [EXP_W-1:0]  exp_sum_i;
  logic [2:0]        rm_i;
  logic              invalid_i;
  logic              is_nan_i;
  logic              is_inf_i;
  logic              is_zero_i;
  logic [XLEN-1:0]   result_o;
  logic [4:0]        fflags_o;
  logic              valid_o;
  logic              busy_o;

  modport master (
    output product_i, product_valid_i, sign_i, exp_sum_i, rm_i,
           invalid_i, is_nan_i, is_inf_i, is_zero_i,
    input  result_o, fflags_o, valid_o, busy_o
  );

  modport slave (
    input  product_i, product_valid_i, sign_i, exp_sum_i, rm_i,
           invalid_i, is_nan_i, is_inf_i, is_zero_i,
    output result_o, fflags_o, valid_o, busy_o
  );

endinterface

// File: rtl/mgt_01_fp_mul_normround_fp_round_incr.sv
// Rounding decision and mantissa increment; shared with the FP add path.
module fp_round_incr
  import mgt_01_fp_mul_normround_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic              g,
  input  logic              s,
  input  logic              sign,
  input  logic [2:0]        rm,
  output logic [MANT_W-1:0] mant_rnd_c,
  output logic              carry_c,
  output logic              inexact_c
);

  localparam int unsigned SUM_W = MANT_W + 1;

  logic up;

  // Unlisted encodings fall back to round-to-nearest-even.
  always_comb begin
    up = 1'b0;
    case (rm)
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = sign & (g | s);
      RM_RUP:  up = ~sign & (g | s);
      RM_RMM:  up = g;
      default: up = g & (s | mant[0]);
    endcase
  end

  assign {carry_c, mant_rnd_c} = {1'b0, mant} + SUM_W'(up);
  assign inexact_c = g | s;

endmodule

// File: rtl/mgt_01_fp_mul_normround.sv
// Post-multiply stage: normalise the 48-bit mantissa product, round, and pack binary32 + fflags.
module mgt_01_fp_mul_normround
  import mgt_01_fp_mul_normround_pkg::*;
(
  input logic                      clk_i,
  input logic                      clk_en_i,
  input logic                      rst_n_i,
  mgt_01_fp_mul_normround_if.slave bus
);

  localparam int unsigned NEXP_W = EXP_W + 1;

  state_e                   state_q;
  logic [PROD_W-1:0]        prod_q;
  logic                     sign_q;
  logic [EXP_W-1:0]         exp_q;
  logic [2:0]               rm_q;
  logic                     invalid_q, nan_q, inf_q, zero_q;
  logic [MANT_W-1:0]        mant_q;
  logic                     g_q, s_q;
  logic signed [NEXP_W-1:0] nexp_q;

  logic [MANT_W-1:0]        mant_rnd_c;
  logic                     carry_c, inexact_c;
  logic signed [NEXP_W-1:0] exp_ext_c, fexp_c;
  logic [XLEN-1:0]          res_c, inf_c, max_c;
  fflags_t                  flags_c;
  logic                     unused_hi_c;

  // Upper product bits are always zero for binary32 mantissas.
  assign unused_hi_c = ^bus.product_i[2*XLEN-1:PROD_W];

  fp_round_incr u_round (
    .mant       (mant_q),
    .g          (g_q),
    .s          (s_q),
    .sign       (sign_q),
    .rm         (rm_q),
    .mant_rnd_c (mant_rnd_c),
    .carry_c    (carry_c),
    .inexact_c  (inexact_c)
  );

  // One extra exponent bit so the +1 from normalise and round carry cannot wrap.
  assign exp_ext_c = $signed({exp_q[EXP_W-1], exp_q});
  assign fexp_c    = nexp_q + $signed({{EXP_W{1'b0}}, carry_c});
  assign inf_c     = pack_fp(sign_q, 8'hFF, '0);
  assign max_c     = pack_fp(sign_q, 8'hFE, '1);

  // Final result selection: specials, overflow, underflow, then normal.
  always_comb begin
    res_c   = '0;
    flags_c = '0;
    if (invalid_q) begin
      res_c      = CANON_NAN;
      flags_c.nv = 1'b1;
    end else if (nan_q) begin
      res_c = CANON_NAN;
    end else if (inf_q) begin
      res_c = inf_c;
    end else if (zero_q) begin
      res_c = pack_fp(sign_q, 8'h00, '0);
    end else if (fexp_c >= $signed(NEXP_W'(EXP_MAX))) begin
      flags_c.of = 1'b1;
      flags_c.nx = 1'b1;
      case (rm_q)
        RM_RTZ:  res_c = max_c;
        RM_RDN:  res_c = sign_q ? inf_c : max_c;
        RM_RUP:  res_c = sign_q ? max_c : inf_c;
        default: res_c = inf_c;
      endcase
    end else if (fexp_c <= $signed(NEXP_W'(0))) begin
      res_c      = pack_fp(sign_q, 8'h00, '0);
      flags_c.uf = 1'b1;
      flags_c.nx = 1'b1;
    end else begin
      res_c      = pack_fp(sign_q, fexp_c[7:0], mant_rnd_c);
      flags_c.nx = inexact_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      bus.result_o <= '0;
      bus.fflags_o <= '0;
      bus.valid_o  <= 1'b0;
      bus.busy_o   <= 1'b0;
    end else if (clk_en_i) begin
      case (state_q)
        ST_IDLE: begin
          bus.valid_o <= 1'b0;
          if (bus.product_valid_i) begin
            prod_q     <= bus.product_i[PROD_W-1:0];
            sign_q     <= bus.sign_i;
            exp_q      <= bus.exp_sum_i;
            rm_q       <= bus.rm_i;
            invalid_q  <= bus.invalid_i;
            nan_q      <= bus.is_nan_i;
            inf_q      <= bus.is_inf_i;
            zero_q     <= bus.is_zero_i;
            bus.busy_o <= 1'b1;
            state_q    <= ST_NORMALIZE;
          end
        end
        // Leading one sits at bit 47 or 46 since subnormals are already flushed.
        ST_NORMALIZE: begin
          if (prod_q[PROD_W-1]) begin
            mant_q <= prod_q[46:24];
            g_q    <= prod_q[23];
            s_q    <= |prod_q[22:0];
            nexp_q <= exp_ext_c + $signed(NEXP_W'(1));
          end else begin
            mant_q <= prod_q[45:23];
            g_q    <= prod_q[22];
            s_q    <= |prod_q[21:0];
            nexp_q <= exp_ext_c;
          end
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          bus.result_o <= res_c;
          bus.fflags_o <= flags_c;
          bus.valid_o  <= 1'b1;
          state_q      <= ST_VALID;
        end
        ST_VALID: begin
          bus.valid_o <= 1'b0;
          bus.busy_o  <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mgt_01_fp_mul_normround.sv
// Directed bench for the FP multiply normalise/round stage.
module tb_mgt_01_fp_mul_normround;
  import mgt_01_fp_mul_normround_pkg::*;

  logic clk = 1'b0;
  logic clk_en;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mgt_01_fp_mul_normround_if bus ();

  mgt_01_fp_mul_normround dut (
    .clk_i    (clk),
    .clk_en_i (clk_en),
    .rst_n_i  (rst_n),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One operation: pulse inputs, optionally inject a second pulse while busy or a clock-enable stall.
  task automatic do_op(input string tag, input logic [63:0] p, input logic [9:0] e,
                       input logic s, input logic [2:0] rm, input logic [3:0] spec,
                       input logic [31:0] exp_res, input logic [4:0] exp_fl,
                       input int stall, input bit dup);
    int lat;
    int extra;
    @(negedge clk);
    bus.product_i = p;
    bus.exp_sum_i = e;
    bus.sign_i    = s;
    bus.rm_i      = rm;
    {bus.invalid_i, bus.is_nan_i, bus.is_inf_i, bus.is_zero_i} = spec;
    bus.product_valid_i = 1'b1;
    @(negedge clk);
    bus.product_valid_i = 1'b0;
    lat = 1;
    if (dup) begin
      check($sformatf("%s_busy", tag), 32'(bus.busy_o), 32'd1);
      bus.product_valid_i = 1'b1;
      bus.product_i       = 64'h8000_0000_0000;
      bus.exp_sum_i       = 10'd254;
      @(negedge clk);
      lat++;
      bus.product_valid_i = 1'b0;
    end
    if (stall > 0) begin
      clk_en = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        lat++;
      end
      clk_en = 1'b1;
    end
    while (!bus.valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s_lat", tag), 32'(lat), 32'(3 + stall));
    check($sformatf("%s_res", tag), bus.result_o, exp_res);
    check($sformatf("%s_flags", tag), 32'(bus.fflags_o), 32'(exp_fl));
    @(negedge clk);
    check($sformatf("%s_pulse", tag), 32'(bus.valid_o), 32'd0);
    if (dup) begin
      extra = 0;
      repeat (6) begin
        @(negedge clk);
        if (bus.valid_o) extra++;
      end
      check($sformatf("%s_extra_valid", tag), 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int vcount;
    clk_en              = 1'b1;
    rst_n               = 1'b0;
    bus.product_i       = '0;
    bus.product_valid_i = 1'b0;
    bus.sign_i          = 1'b0;
    bus.exp_sum_i       = '0;
    bus.rm_i            = '0;
    bus.invalid_i       = 1'b0;
    bus.is_nan_i        = 1'b0;
    bus.is_inf_i        = 1'b0;
    bus.is_zero_i       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", bus.result_o, 32'h0);
    check("rst_fflags", 32'(bus.fflags_o), 32'h0);
    check("rst_valid", 32'(bus.valid_o), 32'h0);
    check("rst_busy", 32'(bus.busy_o), 32'h0);
    rst_n = 1'b1;

    do_op("mul15",      64'h9000_0000_0000, 10'd127, 1'b0, 3'd0, 4'b0000, 32'h4010_0000, 5'b00000, 0, 1'b0);
    do_op("g_rne",      64'h4000_0040_0000, 10'd127, 1'b0, 3'd0, 4'b0000, 32'h3F80_0000, 5'b00001, 0, 1'b0);
    do_op("g_rup",      64'h4000_0040_0000, 10'd127, 1'b0, 3'd3, 4'b0000, 32'h3F80_0001, 5'b00001, 0, 1'b0);
    do_op("g_rtz",      64'h4000_0040_0000, 10'd127, 1'b0, 3'd1, 4'b0000, 32'h3F80_0000, 5'b00001, 0, 1'b0);
    do_op("g_rmm",      64'h4000_0040_0000, 10'd127, 1'b0, 3'd4, 4'b0000, 32'h3F80_0001, 5'b00001, 0, 1'b0);
    do_op("g_rdn_neg",  64'h4000_0040_0000, 10'd127, 1'b1, 3'd2, 4'b0000, 32'hBF80_0001, 5'b00001, 0, 1'b0);
    do_op("carry",      64'h7FFF_FFC0_0000, 10'd127, 1'b0, 3'd0, 4'b0000, 32'h4000_0000, 5'b00001, 0, 1'b0);
    do_op("carry_rm7",  64'h7FFF_FFC0_0000, 10'd127, 1'b0, 3'd7, 4'b0000, 32'h4000_0000, 5'b00001, 0, 1'b0);
    do_op("ovf_rne",    64'h8000_0000_0000, 10'd254, 1'b0, 3'd0, 4'b0000, 32'h7F80_0000, 5'b00101, 0, 1'b0);
    do_op("ovf_rtz",    64'h8000_0000_0000, 10'd254, 1'b0, 3'd1, 4'b0000, 32'h7F7F_FFFF, 5'b00101, 0, 1'b0);
    do_op("ovf_rdn_n",  64'h8000_0000_0000, 10'd254, 1'b1, 3'd2, 4'b0000, 32'hFF80_0000, 5'b00101, 0, 1'b0);
    do_op("ovf_rup_n",  64'h8000_0000_0000, 10'd254, 1'b1, 3'd3, 4'b0000, 32'hFF7F_FFFF, 5'b00101, 0, 1'b0);
    do_op("uflow",      64'h4000_0000_0001, 10'd0,   1'b1, 3'd0, 4'b0000, 32'h8000_0000, 5'b00011, 0, 1'b0);
    do_op("invalid",    64'h9000_0000_0000, 10'd127, 1'b0, 3'd0, 4'b1100, 32'h7FC0_0000, 5'b10000, 0, 1'b0);
    do_op("nan",        64'h9000_0000_0000, 10'd127, 1'b1, 3'd0, 4'b0110, 32'h7FC0_0000, 5'b00000, 0, 1'b0);
    do_op("inf_neg",    64'h9000_0000_0000, 10'd127, 1'b1, 3'd0, 4'b0011, 32'hFF80_0000, 5'b00000, 0, 1'b0);
    do_op("zero_neg",   64'h9000_0000_0000, 10'd127, 1'b1, 3'd0, 4'b0001, 32'h8000_0000, 5'b00000, 0, 1'b0);
    do_op("dup_busy",   64'h9000_0000_0000, 10'd127, 1'b0, 3'd0, 4'b0000, 32'h4010_0000, 5'b00000, 0, 1'b1);
    do_op("stall5",     64'h9000_0000_0000, 10'd127, 1'b0, 3'd0, 4'b0000, 32'h4010_0000, 5'b00000, 5, 1'b0);

    // Reset asserted while the operation sits in ROUND.
    @(negedge clk);
    bus.product_i       = 64'h9000_0000_0000;
    bus.exp_sum_i       = 10'd127;
    bus.sign_i          = 1'b0;
    bus.rm_i            = 3'd0;
    bus.product_valid_i = 1'b1;
    @(negedge clk);
    bus.product_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(bus.valid_o), 32'd0);
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    check("midrst_result", bus.result_o, 32'h0);
    rst_n  = 1'b1;
    vcount = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.valid_o) vcount++;
    end
    check("midrst_no_valid", 32'(vcount), 32'd0);

    do_op("post_rst",   64'h4000_0040_0000, 10'd127, 1'b0, 3'd3, 4'b0000, 32'h3F80_0001, 5'b00001, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
